// File: rtl/fp16_mul_arbiter.sv
// Round-robin arbiter that shares one pipelined FP16 multiplier between NUM_REQ requesters,
// tagging each issue so results return to their originator. FP16_MUL_ARB_PERF_EN adds issue_count.
module fp16_mul_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MAX_INFLIGHT = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [15:0]           resp_data,
  output logic                  m_a_tvalid,
  output logic                  m_b_tvalid,
  output logic [15:0]           m_a_tdata,
  output logic [15:0]           m_b_tdata,
  input  logic                  s_result_tvalid,
  input  logic [15:0]           s_result_tdata,
  output logic                  busy,
`ifdef FP16_MUL_ARB_PERF_EN
  output logic [31:0]           issue_count,
`endif
  output logic                  err_spurious
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PtrW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [IdxW-1:0]    tag_mem_q [MAX_INFLIGHT];
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [15:0]        resp_data_q, resp_data_d;
  logic               m_tvalid_q, m_tvalid_d;
  logic [15:0]        m_a_tdata_q, m_a_tdata_d, m_b_tdata_q, m_b_tdata_d;
  logic               err_q, err_d;

  logic               full, pop, can_push, found, push;
  logic [IdxW-1:0]    gnt_idx, cand;
  logic [IdxW-1:0]    pop_tag;

  assign full    = (count_q == CntW'(MAX_INFLIGHT));
  assign pop     = s_result_tvalid && (count_q != '0);
  assign pop_tag = tag_mem_q[rd_ptr_q];
  // A pop in the same cycle frees a slot, so a full FIFO may still accept a grant.
  assign can_push = aresetn && (!full || pop);

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IdxW'((32'(rr_ptr_q) + off) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign push      = found && can_push;
  assign req_ready = push ? (NUM_REQ'(1) << gnt_idx) : '0;

  always_comb begin
    rr_ptr_d     = push ? gnt_idx : rr_ptr_q;
    wr_ptr_d     = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d      = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
    resp_valid_d = pop ? (NUM_REQ'(1) << pop_tag) : '0;
    resp_data_d  = pop ? s_result_tdata : resp_data_q;
    m_tvalid_d   = push;
    m_a_tdata_d  = push ? req_a[16*gnt_idx +: 16] : m_a_tdata_q;
    m_b_tdata_d  = push ? req_b[16*gnt_idx +: 16] : m_b_tdata_q;
    err_d        = err_q || (s_result_tvalid && !pop);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr_q     <= IdxW'(NUM_REQ - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      m_tvalid_q   <= 1'b0;
      m_a_tdata_q  <= '0;
      m_b_tdata_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      m_tvalid_q   <= m_tvalid_d;
      m_a_tdata_q  <= m_a_tdata_d;
      m_b_tdata_q  <= m_b_tdata_d;
      err_q        <= err_d;
    end
  end

  // Tag storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge aclk) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= gnt_idx;
    end
  end

`ifdef FP16_MUL_ARB_PERF_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;

  assign issue_cnt_d = push ? issue_cnt_q + 32'd1 : issue_cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      issue_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign issue_count = issue_cnt_q;
`endif

  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign m_a_tvalid   = m_tvalid_q;
  assign m_b_tvalid   = m_tvalid_q;
  assign m_a_tdata    = m_a_tdata_q;
  assign m_b_tdata    = m_b_tdata_q;
  assign busy         = (count_q != '0);
  assign err_spurious = err_q;

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Directed self-checking bench for fp16_mul_arbiter (NUM_REQ=4, MAX_INFLIGHT=8); the bench
// plays the multiplier by driving s_result_* by hand.
module tb_fp16_mul_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic [15:0] resp_data;
  logic        m_a_tvalid, m_b_tvalid;
  logic [15:0] m_a_tdata, m_b_tdata;
  logic        s_result_tvalid = 1'b0;
  logic [15:0] s_result_tdata = '0;
  logic        busy;
  logic        err_spurious;
`ifdef FP16_MUL_ARB_PERF_EN
  logic [31:0] issue_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fp16_mul_arbiter #(
    .NUM_REQ      (4),
    .MAX_INFLIGHT (8)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .req_valid       (req_valid),
    .req_a           (req_a),
    .req_b           (req_b),
    .req_ready       (req_ready),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .m_a_tvalid      (m_a_tvalid),
    .m_b_tvalid      (m_b_tvalid),
    .m_a_tdata       (m_a_tdata),
    .m_b_tdata       (m_b_tdata),
    .s_result_tvalid (s_result_tvalid),
    .s_result_tdata  (s_result_tdata),
    .busy            (busy),
`ifdef FP16_MUL_ARB_PERF_EN
    .issue_count     (issue_count),
`endif
    .err_spurious    (err_spurious)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required normal finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    req_valid       = '0;
    s_result_tvalid = 1'b0;
    aresetn         = 1'b0;
    step();
    step();
    aresetn = 1'b1;
  endtask

  task automatic set_ops(input logic [15:0] a, input logic [15:0] b);
    req_a = {4{a}};
    req_b = {4{b}};
  endtask

  logic [3:0] exp_gnt [5];
  int         gnt_cnt;

  initial begin
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
    exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;

    // Reset state
    do_reset();
    @(negedge aclk);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_data", 32'(resp_data), 32'h0);
    check("rst_m_tvalid", {30'b0, m_a_tvalid, m_b_tvalid}, 32'h0);
    check("rst_m_tdata", {m_a_tdata, m_b_tdata}, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err_spurious), 32'h0);
`ifdef FP16_MUL_ARB_PERF_EN
    check("rst_issue_count", issue_count, 32'h0);
`endif

    // Single operation: 2.0 * 2.0 = 4.0
    step();
    set_ops(16'h4000, 16'h4000);
    req_valid = 4'b0001;
    @(negedge aclk);
    check("single_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    @(negedge aclk);
    check("single_m_tvalid", {30'b0, m_a_tvalid, m_b_tvalid}, 32'h3);
    check("single_m_tdata", {m_a_tdata, m_b_tdata}, 32'h4000_4000);
    check("single_busy", 32'(busy), 32'h1);
    step();
    @(negedge aclk);
    check("single_m_tvalid_pulse", 32'(m_a_tvalid), 32'h0);
    step();
    s_result_tvalid = 1'b1;
    s_result_tdata  = 16'h4400;
    @(negedge aclk);
    check("single_resp_early", 32'(resp_valid), 32'h0);
    step();
    s_result_tvalid = 1'b0;
    @(negedge aclk);
    check("single_resp_valid", 32'(resp_valid), 32'h1);
    check("single_resp_data", 32'(resp_data), 32'h4400);
    check("single_busy_done", 32'(busy), 32'h0);
    step();
    @(negedge aclk);
    check("single_resp_pulse", 32'(resp_valid), 32'h0);

    // Round robin from reset with all requesters valid
    do_reset();
    set_ops(16'h3C00, 16'h4200);
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      check($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(exp_gnt[k]));
      if (k > 0) check($sformatf("rr_m_tvalid%0d", k), 32'(m_a_tvalid), 32'h1);
      step();
    end
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      s_result_tvalid = (k < 5);
      s_result_tdata  = 16'h4200;
      @(negedge aclk);
      if (k > 0) begin
        check($sformatf("rr_resp_valid%0d", k - 1), 32'(resp_valid), 32'(exp_gnt[k-1]));
        check($sformatf("rr_resp_data%0d", k - 1), 32'(resp_data), 32'h4200);
      end
      step();
    end
    s_result_tvalid = 1'b0;
    @(negedge aclk);
    check("rr_busy_done", 32'(busy), 32'h0);
    check("rr_no_err", 32'(err_spurious), 32'h0);

    // Long latency: fill to MAX_INFLIGHT then stall until a result returns
    do_reset();
    req_valid = 4'hF;
    gnt_cnt   = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge aclk);
      if (req_ready != '0) gnt_cnt++;
      step();
    end
    check("full_grant_count", 32'(gnt_cnt), 32'd8);
    @(negedge aclk);
    check("full_ready_stall", 32'(req_ready), 32'h0);
    check("full_busy", 32'(busy), 32'h1);
    step();
    s_result_tvalid = 1'b1;
    s_result_tdata  = 16'h1234;
    @(negedge aclk);
    check("full_grant_on_result", 32'(req_ready), 32'h1);
    step();
    s_result_tvalid = 1'b0;
    @(negedge aclk);
    check("full_resp_tag0", 32'(resp_valid), 32'h1);
    check("full_count_unchanged", 32'(req_ready), 32'h0);
    step();
    req_valid = '0;

    // Push and pop together at a single entry keeps the FIFO occupied
    do_reset();
    req_valid = 4'b0010;
    step();
    s_result_tvalid = 1'b1;
    s_result_tdata  = 16'h5555;
    @(negedge aclk);
    check("one_entry_ready", 32'(req_ready), 32'h2);
    step();
    s_result_tvalid = 1'b0;
    req_valid       = '0;
    @(negedge aclk);
    check("one_entry_resp", 32'(resp_valid), 32'h2);
    check("one_entry_busy", 32'(busy), 32'h1);

    // Spurious result with nothing outstanding
    do_reset();
    s_result_tvalid = 1'b1;
    s_result_tdata  = 16'hBEEF;
    step();
    s_result_tvalid = 1'b0;
    @(negedge aclk);
    check("spur_resp_valid", 32'(resp_valid), 32'h0);
    check("spur_err", 32'(err_spurious), 32'h1);
    step();
    step();
    @(negedge aclk);
    check("spur_err_sticky", 32'(err_spurious), 32'h1);
    do_reset();
    @(negedge aclk);
    check("spur_err_cleared", 32'(err_spurious), 32'h0);

    // Reset with three operations in flight
    step();
    set_ops(16'h3C00, 16'h3C00);
    req_valid = 4'hF;
    step();
    step();
    step();
    req_valid = '0;
    aresetn   = 1'b0;
    #1;
    check("midrst_ready", 32'(req_ready), 32'h0);
    check("midrst_m_tvalid", {30'b0, m_a_tvalid, m_b_tvalid}, 32'h0);
    check("midrst_m_tdata", {m_a_tdata, m_b_tdata}, 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_resp", {12'b0, resp_valid, resp_data}, 32'h0);
    step();
    aresetn = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      s_result_tvalid = 1'b1;
      s_result_tdata  = 16'h3C00;
      step();
      s_result_tvalid = 1'b0;
      @(negedge aclk);
      check($sformatf("midrst_late_resp%0d", k), 32'(resp_valid), 32'h0);
      step();
    end
    @(negedge aclk);
    check("midrst_err", 32'(err_spurious), 32'h1);
    step();
    set_ops(16'h4000, 16'h4200);
    req_valid = 4'b0100;
    @(negedge aclk);
    check("midrst_req2_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    @(negedge aclk);
    check("midrst_req2_m", {15'b0, m_a_tvalid, m_a_tdata}, 32'h1_4000);

`ifdef FP16_MUL_ARB_PERF_EN
    // Ten grants counted, then cleared by reset
    do_reset();
    for (int k = 0; k < 10; k++) begin
      req_valid = 4'b0001;
      s_result_tvalid = (k > 0);
      step();
    end
    req_valid       = '0;
    s_result_tvalid = 1'b1;
    step();
    s_result_tvalid = 1'b0;
    @(negedge aclk);
    check("perf_issue_count", issue_count, 32'd10);
    do_reset();
    @(negedge aclk);
    check("perf_issue_count_rst", issue_count, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
